// File: rtl/weight_update_sequencer_if.sv
// Operand/result bus between the weight update sequencer and the
// combinational per-weight updater.
interface weight_update_sequencer_if;
  logic [31:0] upd_weight;
  logic [31:0] upd_backprop;
  logic [31:0] upd_train_mul;
  logic [31:0] upd_train_div;
  logic [31:0] upd_weight_new;

  modport master (
    output upd_weight,
    output upd_backprop,
    output upd_train_mul,
    output upd_train_div,
    input  upd_weight_new
  );

  modport slave (
    input  upd_weight,
    input  upd_backprop,
    input  upd_train_mul,
    input  upd_train_div,
    output upd_weight_new
  );
endinterface

// File: rtl/weight_update_sequencer.sv
// Walks one neuron's weight vector through the external updater, one weight
// per cycle, writing results back in place. Optional macro: WEIGHT_SAT_EN.
module weight_update_sequencer #(
  parameter int                 N_WEIGHTS = 8,
  parameter logic signed [31:0] WMAX      = 32'sd65536,
  localparam int                IW        = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [31:0]               backprop_in,
  input  logic [31:0]               train_mul_in,
  input  logic [31:0]               train_div_in,
  input  logic                      wr_en,
  input  logic [IW-1:0]             wr_addr,
  input  logic [31:0]               wr_data,
  input  logic [IW-1:0]             rd_addr,
  output logic [31:0]               rd_data,
  weight_update_sequencer_if.master upd,
  output logic                      busy,
  output logic                      done,
  output logic                      div_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_WEIGHTS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);

  state_t        state_r;
  logic [IW-1:0] idx_r;
  logic [31:0]   weights_r [N_WEIGHTS];
  logic [31:0]   backprop_r;
  logic [31:0]   train_mul_r;
  logic [31:0]   train_div_r;
  logic          busy_r;
  logic          done_r;
  logic          div_err_r;

  logic [31:0]   rd_data_s;
  logic [31:0]   upd_weight_s;
  logic [31:0]   store_s;
  logic          wr_ok_s;

`ifdef WEIGHT_SAT_EN
  function automatic logic [31:0] store_value(input logic signed [31:0] w);
    if (w > WMAX) begin
      return WMAX;
    end else if (w < -WMAX) begin
      return -WMAX;
    end else begin
      return w;
    end
  endfunction
`else
  logic unused_wmax_s;
  assign unused_wmax_s = ^WMAX;

  function automatic logic [31:0] store_value(input logic signed [31:0] w);
    return w;
  endfunction
`endif

  // Read port, updater operand selection and write-back value
  always_comb begin
    rd_data_s    = 32'd0;
    upd_weight_s = weights_r[0];
    wr_ok_s      = 1'b0;
    if (int'(rd_addr) < N_WEIGHTS) begin
      rd_data_s = weights_r[rd_addr];
    end else begin
      rd_data_s = 32'd0;
    end
    if (state_r == ST_UPDATE) begin
      upd_weight_s = weights_r[idx_r];
    end else begin
      upd_weight_s = weights_r[0];
    end
    if (int'(wr_addr) < N_WEIGHTS) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
    store_s = store_value(upd.upd_weight_new);
  end

  assign rd_data           = rd_data_s;
  assign upd.upd_weight    = upd_weight_s;
  assign upd.upd_backprop  = backprop_r;
  assign upd.upd_train_mul = train_mul_r;
  assign upd.upd_train_div = train_div_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign div_err           = div_err_r;

  // Sequencer FSM, weight register file and operand latches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      backprop_r  <= 32'd0;
      train_mul_r <= 32'd0;
      train_div_r <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      div_err_r   <= 1'b0;
      for (int i = 0; i < N_WEIGHTS; i++) begin
        weights_r[i] <= 32'd0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r    <= 1'b0;
          div_err_r <= 1'b0;
          // A load coinciding with start lands before the first update read
          if (wr_en && wr_ok_s) begin
            weights_r[wr_addr] <= wr_data;
          end
          if (start) begin
            if (train_div_in != 32'd0) begin
              backprop_r  <= backprop_in;
              train_mul_r <= train_mul_in;
              train_div_r <= train_div_in;
              idx_r       <= '0;
              busy_r      <= 1'b1;
              state_r     <= ST_UPDATE;
            end else begin
              done_r    <= 1'b1;
              div_err_r <= 1'b1;
              state_r   <= ST_DONE;
            end
          end
        end
        ST_UPDATE: begin
          weights_r[idx_r] <= store_s;
          if (idx_r == LAST_IDX) begin
            idx_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        ST_DONE: begin
          done_r    <= 1'b0;
          div_err_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          idx_r     <= '0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          div_err_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_update_sequencer.sv
// Scoreboard bench for weight_update_sequencer with an updater model w + b*m/d.
module tb_weight_update_sequencer;
  localparam int N  = 4;
  localparam int IW = 2;

  localparam int S_RD   = 0;
  localparam int S_BUSY = 1;
  localparam int S_DONE = 2;
  localparam int S_DERR = 3;
  localparam int S_BP   = 4;
  localparam int S_TDIV = 5;
  localparam int S_UPDW = 6;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  typedef struct {
    logic div_err;
    int   busy_cycles;
  } done_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [31:0]   backprop_in;
  logic [31:0]   train_mul_in;
  logic [31:0]   train_div_in;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [IW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          busy;
  logic          done;
  logic          div_err;

  weight_update_sequencer_if bus ();

  weight_update_sequencer #(.N_WEIGHTS(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .backprop_in  (backprop_in),
    .train_mul_in (train_mul_in),
    .train_div_in (train_div_in),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .upd          (bus.master),
    .busy         (busy),
    .done         (done),
    .div_err      (div_err)
  );

  // Updater model: weightNew = weight + backprop*mul/div (truncating)
  logic signed [63:0] prod_s;
  logic signed [63:0] quot_s;
  always_comb begin
    prod_s = $signed({{32{bus.upd_backprop[31]}}, bus.upd_backprop}) *
             $signed({{32{bus.upd_train_mul[31]}}, bus.upd_train_mul});
    quot_s = 64'sd0;
    if (bus.upd_train_div != 32'd0) begin
      quot_s = prod_s / $signed({{32{bus.upd_train_div[31]}}, bus.upd_train_div});
    end
  end
  assign bus.upd_weight_new = bus.upd_weight + quot_s[31:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  chk_t  chk_q[$];
  done_t done_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    busy_cnt = 0;
  logic  busy_prev = 1'b0;
  logic  done_prev = 1'b0;

  task automatic report(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Monitor: drains probe requests and checks every done pulse
  always @(negedge clk) begin
    chk_t        c;
    done_t       d;
    logic [31:0] act;
    if (!rst_n) begin
      busy_cnt  = 0;
      busy_prev = 1'b0;
      done_prev = 1'b0;
      chk_q.delete();
    end else begin
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        case (c.sel)
          S_RD:    act = rd_data;
          S_BUSY:  act = {31'd0, busy};
          S_DONE:  act = {31'd0, done};
          S_DERR:  act = {31'd0, div_err};
          S_BP:    act = bus.upd_backprop;
          S_TDIV:  act = bus.upd_train_div;
          S_UPDW:  act = bus.upd_weight;
          default: act = 32'hxxxx_xxxx;
        endcase
        report(c.name, act, c.exp);
      end
      report("div_err_implies_done", {31'd0, div_err & ~done}, 32'd0);
      if (done) begin
        n_checks++;
        if (done_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pass pending");
        end else begin
          d = done_q.pop_front();
          report("done_div_err", {31'd0, div_err}, {31'd0, d.div_err});
          report("busy_cycles", busy_cnt, d.busy_cycles);
          report("busy_just_before_done", {31'd0, busy_prev}, {31'd0, (d.busy_cycles > 0)});
          report("busy_low_at_done", {31'd0, busy}, 32'd0);
          report("done_single_cycle", {31'd0, done_prev}, 32'd0);
        end
        busy_cnt = 0;
      end
      if (busy) busy_cnt++;
      busy_prev = busy;
      done_prev = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chk(input int sel, input logic [31:0] exp, input string name);
    chk_q.push_back('{sel: sel, exp: exp, name: name});
  endtask

  task automatic probe(input int sel, input logic [31:0] exp, input string name);
    push_chk(sel, exp, name);
    tick();
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = IW'(addr);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic check_vec(input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3, input string tag);
    logic [31:0] ev [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    for (int i = 0; i < N; i++) begin
      rd_addr = IW'(i);
      probe(S_RD, ev[i], $sformatf("%s_rd%0d", tag, i));
    end
  endtask

  task automatic run_pass(input logic [31:0] b, input logic [31:0] m, input logic [31:0] d,
                          input string tag);
    backprop_in  = b;
    train_mul_in = m;
    train_div_in = d;
    start        = 1'b1;
    if (d == 32'd0) done_q.push_back('{div_err: 1'b1, busy_cycles: 0});
    else            done_q.push_back('{div_err: 1'b0, busy_cycles: N});
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    if (d == 32'd0) begin
      push_chk(S_DERR, 32'd1, {tag, "_div_err"});
      push_chk(S_BUSY, 32'd0, {tag, "_busy"});
      probe(S_DONE, 32'd1, {tag, "_done"});
    end else begin
      for (int i = 0; i < N; i++) probe(S_BUSY, 32'd1, $sformatf("%s_busy%0d", tag, i));
      push_chk(S_BUSY, 32'd0, {tag, "_busy_end"});
      probe(S_DONE, 32'd1, {tag, "_done"});
    end
    probe(S_DONE, 32'd0, {tag, "_done_low"});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_en = 1'b0;
    backprop_in = 32'd0; train_mul_in = 32'd0; train_div_in = 32'd0;
    wr_addr = '0; wr_data = 32'd0; rd_addr = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    push_chk(S_BUSY, 32'd0, "rst_busy");
    push_chk(S_DERR, 32'd0, "rst_div_err");
    probe(S_DONE, 32'd0, "rst_done");
    check_vec(32'd0, 32'd0, 32'd0, 32'd0, "rst");

    load(0, 32'sd10); load(1, -32'sd20); load(2, 32'sd30); load(3, -32'sd40);
    run_pass(32'sd6, 32'sd1, 32'sd2, "p1");
    check_vec(32'sd13, -32'sd17, 32'sd33, -32'sd37, "p1");
    probe(S_UPDW, 32'sd13, "idle_upd_weight");

    run_pass(32'sd7, 32'sd3, 32'd0, "dz");
    check_vec(32'sd13, -32'sd17, 32'sd33, -32'sd37, "dz");
    push_chk(S_BP, 32'sd6, "dz_bp_held");
    probe(S_TDIV, 32'sd2, "dz_div_held");

    // Start and load requests during a pass must both be dropped
    backprop_in = 32'sd6; train_mul_in = 32'sd1; train_div_in = 32'sd2;
    start = 1'b1;
    done_q.push_back('{div_err: 1'b0, busy_cycles: N});
    tick();
    backprop_in = 32'sd100;
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'sd99;
    probe(S_BUSY, 32'd1, "ign_busy0");
    probe(S_BUSY, 32'd1, "ign_busy1");
    probe(S_BUSY, 32'd1, "ign_busy2");
    start = 1'b0; wr_en = 1'b0;
    probe(S_BUSY, 32'd1, "ign_busy3");
    probe(S_DONE, 32'd1, "ign_done");
    probe(S_DONE, 32'd0, "ign_done_low");
    repeat (3) probe(S_BUSY, 32'd0, "ign_no_restart");
    check_vec(32'sd16, -32'sd14, 32'sd36, -32'sd34, "ign");
    probe(S_BP, 32'sd6, "ign_bp_held");

    wr_en = 1'b1; wr_addr = '0; wr_data = 32'sd50;
    run_pass(32'sd6, 32'sd1, 32'sd2, "ld");
    check_vec(32'sd53, -32'sd11, 32'sd39, -32'sd31, "ld");

    // Reset in the third update cycle discards the pass
    backprop_in = 32'sd6; train_mul_in = 32'sd1; train_div_in = 32'sd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push_chk(S_BUSY, 32'd0, "mr_busy");
    probe(S_DONE, 32'd0, "mr_done");
    check_vec(32'd0, 32'd0, 32'd0, 32'd0, "mr");
    repeat (4) probe(S_DONE, 32'd0, "mr_no_done");

`ifdef WEIGHT_SAT_EN
    load(1, 32'sd65000);
    load(2, -32'sd65000);
    run_pass(32'sd5000, 32'sd1, 32'sd1, "s1");
    check_vec(32'sd5000, 32'sd65536, -32'sd60000, 32'sd5000, "s1");
    run_pass(-32'sd10000, 32'sd1, 32'sd1, "s2");
    check_vec(-32'sd5000, 32'sd55536, -32'sd65536, -32'sd5000, "s2");
`endif

    repeat (2) tick();
    n_checks++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_done: got %0d passes without done expected 0", done_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_update_sequencer.md
# weight_update_sequencer

Sequential stage wrapped around the combinational per-weight back-propagation updater. Holds one neuron's weight vector in a register file. On `start`, it latches the back-propagated error and training ratio, then walks the weights one per cycle. For each weight it presents the weight to the updater, captures the updater's `weightNew` and writes it back in place, then signals `done`. It is the downstream consumer of the updater's result and the upstream source of its `weight`/`backprop`/`trainingMul`/`trainingDiv` operands.

## Interface
- `N_WEIGHTS`, 8: weights per neuron (≥1); index width `IW = $clog2(N_WEIGHTS)`, minimum 1.
- `WMAX`, 32'sd65536: saturation magnitude, used only with `WEIGHT_SAT_EN`.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: begin an update pass; sampled only in IDLE.
- `backprop_in` input 32: signed error term, latched on accepted `start`.
- `train_mul_in` input 32: training-rate numerator, latched on accepted `start`.
- `train_div_in` input 32: training-rate denominator, latched on accepted `start`.
- `wr_en` input 1: external weight load; honoured only in IDLE.
- `wr_addr` input IW: load index.
- `wr_data` input 32: load value.
- `rd_addr` input IW: read index.
- `rd_data` output 32: combinational read of `weights[rd_addr]`.
- `upd_weight` output 32: operand to updater `weight`.
- `upd_backprop` output 32: operand to updater `backprop` (latched value).
- `upd_train_mul` output 32: operand to updater `trainingMul` (latched value).
- `upd_train_div` output 32: operand to updater `trainingDiv` (latched value).
- `upd_weight_new` input 32: updater result `weightNew`, combinational from the operands.
- `busy` output 1: high in UPDATE.
- `done` output 1: one-cycle pulse at pass end.
- `div_err` output 1: one-cycle pulse when a pass is rejected for zero divisor.

## Operation
- States: IDLE, UPDATE, DONE.
- IDLE with `start`=1 and `train_div_in`≠0:
  - latch the three operands into registers;
  - set `idx`=0;
  - go to UPDATE.
- IDLE with `start`=1 and `train_div_in`=0:
  - no latch, no weight writes;
  - pulse `div_err` and `done` the following cycle via DONE.
- UPDATE, each cycle:
  - `upd_weight` = `weights[idx]`;
  - at the edge, `weights[idx]` ← `upd_weight_new` (after saturation if enabled);
  - `idx`++.
- Leaving UPDATE: when `idx`=N_WEIGHTS−1 the write completes and the FSM goes to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` during UPDATE or DONE is ignored; it is not queued.
- `wr_en` outside IDLE is ignored.
- `wr_en` and accepted `start` in the same IDLE cycle: the load is performed, and the pass then sees the loaded value.
- Operand registers hold their values until the next accepted `start`.
- In IDLE, `upd_weight` = `weights[0]`.
- Arithmetic: all values are 32-bit two's complement. The sequencer does no arithmetic beyond the optional saturation compare.
- Reset (any state, including mid-pass):
  - FSM to IDLE, `idx`=0;
  - all weights, operand registers, `busy`, `done` and `div_err` = 0;
  - a partially updated vector is discarded (cleared).

## Timing
- Accepted `start` at edge E0: UPDATE occupies cycles E0+1 … E0+N_WEIGHTS.
- `busy`=1 on exactly those cycles.
- `done`=1 in cycle E0+N_WEIGHTS+1; `start` is accepted again from E0+N_WEIGHTS+2.
- Zero-divisor `start` at E0: `done`=`div_err`=1 in cycle E0+1, `busy` stays 0.
- Weight k is written at the end of cycle E0+1+k. `rd_data` reflects the new value from the following cycle.
- Throughput: one pass per N_WEIGHTS+2 cycles.
- The updater path `upd_*` → `upd_weight_new` is a single-cycle combinational path.

## Configuration
- `WEIGHT_SAT_EN` defined: the written value is clamped to [−WMAX, +WMAX] as signed before storing.
- `WEIGHT_SAT_EN` undefined: `upd_weight_new` is stored unmodified and `WMAX` is unused.

## Test plan
- Reset, then observe: `busy`=`done`=`div_err`=0, and `rd_data`=0 for every address.
- N_WEIGHTS=4; load weights {10,−20,30,−40}; bench updater model `w + b*m/d`; `start` with b=6, m=1, d=2.
  - Required: `busy` for 4 cycles, `done` one cycle later.
  - Required: readback {13,−17,33,−37}.
- `start` with `train_div_in`=0 → `div_err` and `done` pulse next cycle, `busy` never 1, weights unchanged.
- Assert `start` again and `wr_en` (addr 0, data 99) during UPDATE → both ignored, a single `done`, and weight 0 holds the pass result.
- Assert `rst_n`=0 in the third UPDATE cycle → next cycle is IDLE, all weights 0, no `done`.
- With `WEIGHT_SAT_EN`: weight 65000, model returns 70000 → stored 65536; model returns −70000 → stored −65536.
